// File: rtl/fft_npt_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_npt_iter : iterative radix-2 DIT FFT, one butterfly per clock.         |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module fft_npt_iter #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int SCALE = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] f_re [N-1:0],
  input  logic signed [WIDTH-1:0] f_im [N-1:0],
  output logic signed [WIDTH-1:0] F_re [N-1:0],
  output logic signed [WIDTH-1:0] F_im [N-1:0],
  output logic                    busy,
  output logic                    done
);

  localparam int AW         = $clog2(N);
  localparam int C_TW_SHIFT = 4 - AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_mem_re [N];
  logic signed [WIDTH-1:0] r_mem_im [N];
  logic [2:0]              r_stage;
  logic [AW-1:0]           r_j;
  logic [AW-1:0]           r_top;
  logic [AW-1:0]           r_bot;
  logic [AW-1:0]           r_k;
  logic                    r_gen_done;
  logic                    r_av;
  logic                    r_alast;

  function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] x);
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) r[b] = x[AW-1-b];
    return r;
  endfunction

  // Address generation runs one cycle ahead of the butterfly datapath.
  logic [AW-1:0] w_mask;
  logic [AW-1:0] w_top;
  logic [AW-1:0] w_bot;
  logic [AW-1:0] w_k;
  logic [2:0]    w_stage_p1;
  logic [2:0]    w_kshift;
  logic          w_last;

  always_comb begin
    w_stage_p1 = r_stage + 3'd1;
    w_kshift   = 3'(AW - 1) - r_stage;
    w_mask     = (AW'(1) << r_stage) - AW'(1);
    w_top      = ((r_j >> r_stage) << w_stage_p1) | (r_j & w_mask);
    w_bot      = w_top | (AW'(1) << r_stage);
    w_k        = (r_j & w_mask) << w_kshift;
    w_last     = (r_stage == 3'(AW - 1)) && (r_j == AW'(N / 2 - 1));
  end

  // Twiddles are stored once for a 16-point transform and strided for smaller N.
  logic [3:0]         w_m;
  logic signed [15:0] w_wr;
  logic signed [15:0] w_wi;

  always_comb begin
    w_m = 4'(r_k) << C_TW_SHIFT;
    case (w_m)
      4'd1:    begin w_wr =  16'sd15137; w_wi = -16'sd6270;  end
      4'd2:    begin w_wr =  16'sd11585; w_wi = -16'sd11585; end
      4'd3:    begin w_wr =  16'sd6270;  w_wi = -16'sd15137; end
      4'd4:    begin w_wr =  16'sd0;     w_wi = -16'sd16384; end
      4'd5:    begin w_wr = -16'sd6270;  w_wi = -16'sd15137; end
      4'd6:    begin w_wr = -16'sd11585; w_wi = -16'sd11585; end
      4'd7:    begin w_wr = -16'sd15137; w_wi = -16'sd6270;  end
      default: begin w_wr =  16'sd16384; w_wi =  16'sd0;     end
    endcase
  end

  logic signed [WIDTH-1:0]  w_a_re, w_a_im, w_b_re, w_b_im;
  logic signed [WIDTH+15:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [WIDTH+16:0] w_t_re_full, w_t_im_full;
  logic signed [WIDTH:0]    w_t_re, w_t_im;
  logic signed [WIDTH:0]    w_s_re, w_s_im, w_d_re, w_d_im;
  logic signed [WIDTH-1:0]  w_y0_re, w_y0_im, w_y1_re, w_y1_im;

  always_comb begin
    w_a_re      = r_mem_re[r_top];
    w_a_im      = r_mem_im[r_top];
    w_b_re      = r_mem_re[r_bot];
    w_b_im      = r_mem_im[r_bot];
    w_p_rr      = (WIDTH+16)'(w_wr) * (WIDTH+16)'(w_b_re);
    w_p_ii      = (WIDTH+16)'(w_wi) * (WIDTH+16)'(w_b_im);
    w_p_ri      = (WIDTH+16)'(w_wr) * (WIDTH+16)'(w_b_im);
    w_p_ir      = (WIDTH+16)'(w_wi) * (WIDTH+16)'(w_b_re);
    w_t_re_full = ((WIDTH+17)'(w_p_rr) - (WIDTH+17)'(w_p_ii)) >>> 14;
    w_t_im_full = ((WIDTH+17)'(w_p_ri) + (WIDTH+17)'(w_p_ir)) >>> 14;
    w_t_re      = (WIDTH+1)'(w_t_re_full);
    w_t_im      = (WIDTH+1)'(w_t_im_full);
    w_s_re      = (WIDTH+1)'(w_a_re) + w_t_re;
    w_s_im      = (WIDTH+1)'(w_a_im) + w_t_im;
    w_d_re      = (WIDTH+1)'(w_a_re) - w_t_re;
    w_d_im      = (WIDTH+1)'(w_a_im) - w_t_im;
    if (SCALE != 0) begin
      w_s_re = w_s_re >>> 1;
      w_s_im = w_s_im >>> 1;
      w_d_re = w_d_re >>> 1;
      w_d_im = w_d_im >>> 1;
    end
    w_y0_re = WIDTH'(w_s_re);
    w_y0_im = WIDTH'(w_s_im);
    w_y1_re = WIDTH'(w_d_re);
    w_y1_im = WIDTH'(w_d_im);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      r_stage    <= 3'd0;
      r_j        <= '0;
      r_top      <= '0;
      r_bot      <= '0;
      r_k        <= '0;
      r_gen_done <= 1'b0;
      r_av       <= 1'b0;
      r_alast    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_mem_re[i] <= '0;
        r_mem_im[i] <= '0;
        F_re[i]     <= '0;
        F_im[i]     <= '0;
      end
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            for (int i = 0; i < N; i++) begin
              r_mem_re[i] <= f_re[f_bitrev(AW'(i))];
              r_mem_im[i] <= f_im[f_bitrev(AW'(i))];
            end
            r_stage    <= 3'd0;
            r_j        <= '0;
            r_gen_done <= 1'b0;
            r_av       <= 1'b0;
            r_alast    <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            r_state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (r_av) begin
            r_mem_re[r_top] <= w_y0_re;
            r_mem_im[r_top] <= w_y0_im;
            r_mem_re[r_bot] <= w_y1_re;
            r_mem_im[r_bot] <= w_y1_im;
            if (r_alast) r_state <= OUTPUT;
          end
          if (!r_gen_done) begin
            r_top   <= w_top;
            r_bot   <= w_bot;
            r_k     <= w_k;
            r_av    <= 1'b1;
            r_alast <= w_last;
            if (w_last) begin
              r_gen_done <= 1'b1;
            end else if (r_j == AW'(N / 2 - 1)) begin
              r_j     <= '0;
              r_stage <= r_stage + 3'd1;
            end else begin
              r_j <= r_j + AW'(1);
            end
          end else begin
            r_av <= 1'b0;
          end
        end
        OUTPUT: begin
          for (int i = 0; i < N; i++) begin
            F_re[i] <= r_mem_re[i];
            F_im[i] <= r_mem_im[i];
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
